// File: rtl/jpeg_bit_packer_if.sv
// Handshake bundle between the Huffman encode controller, the byte packer and the file writer.
`timescale 1ns/1ps
interface jpeg_bit_packer_if #(
  parameter int IN_WIDTH = 32
);
  localparam int LEN_W = $clog2(IN_WIDTH + 1);

  logic                in_valid;
  logic                in_ready;
  logic [IN_WIDTH-1:0] in_bits;
  logic [LEN_W-1:0]    in_len;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [7:0]          out_byte;
  logic                flush_done;
  logic                busy;

  modport master (
    output in_valid, in_bits, in_len, flush, out_ready,
    input  in_ready, out_valid, out_byte, flush_done, busy
  );

  modport slave (
    input  in_valid, in_bits, in_len, flush, out_ready,
    output in_ready, out_valid, out_byte, flush_done, busy
  );
endinterface

// File: rtl/jpeg_bit_packer.sv
// MSB-first code word packer emitting entropy-coded bytes with 1-padding on flush.
// Define JPEG_BYTE_STUFF_EN to insert a 0x00 after every emitted 0xFF data byte.
`timescale 1ns/1ps
module jpeg_bit_packer #(
  parameter int IN_WIDTH  = 32,
  parameter int ACC_WIDTH = 64   // must be >= IN_WIDTH + 8 and a multiple of 8
) (
  input  logic               clk,
  input  logic               rst,
  jpeg_bit_packer_if.slave   bus
);
  localparam int LEN_W  = $clog2(IN_WIDTH + 1);
  localparam int FILL_W = $clog2(ACC_WIDTH + 1);

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic                   stuff_pending_q, stuff_pending_d;
  logic                   out_valid_q, out_valid_d;
  logic [7:0]             out_byte_q, out_byte_d;
  logic                   flush_done_q, flush_done_d;
  logic                   busy_q, busy_d;

  logic                   in_ready_c, accept, take_flush;
  logic                   out_free, load_stuff, load_data;
  logic [LEN_W-1:0]       len_c;
  logic [IN_WIDTH-1:0]    word;
  logic [ACC_WIDTH-1:0]   acc_sh, acc_a, word_ext, pad_mask;
  logic [FILL_W-1:0]      fill_sh, fill_a, fill_up, fill_r, sh_amt;
  logic [7:0]             data_byte;

  // Mask covering the top n bits of the accumulator.
  function automatic logic [ACC_WIDTH-1:0] top_mask(input logic [FILL_W-1:0] n);
    return ~({ACC_WIDTH{1'b1}} >> n);
  endfunction

  assign in_ready_c     = (state_q == RUN) && (fill_q <= FILL_W'(ACC_WIDTH - IN_WIDTH));
  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_byte   = out_byte_q;
  assign bus.flush_done = flush_done_q;
  assign bus.busy       = busy_q;

  always_comb begin
    accept     = bus.in_valid && in_ready_c;
    take_flush = bus.flush && in_ready_c;
    out_free   = !out_valid_q || bus.out_ready;
    load_stuff = out_free && stuff_pending_q;
    load_data  = out_free && !stuff_pending_q && (fill_q >= FILL_W'(8));
    data_byte  = acc_q[ACC_WIDTH-1 -: 8];

    len_c = (bus.in_len > LEN_W'(IN_WIDTH)) ? LEN_W'(IN_WIDTH) : bus.in_len;
    word  = bus.in_bits & ~({IN_WIDTH{1'b1}} << len_c);

    // Drain first, then append, so a same-cycle word lands after the shifted bits.
    acc_sh  = load_data ? (acc_q << 8) : acc_q;
    fill_sh = load_data ? (fill_q - FILL_W'(8)) : fill_q;
    fill_a  = accept ? (fill_sh + FILL_W'(len_c)) : fill_sh;
    sh_amt  = FILL_W'(ACC_WIDTH) - fill_a;
    word_ext = accept ? ({{(ACC_WIDTH-IN_WIDTH){1'b0}}, word} << sh_amt) : '0;
    acc_a    = acc_sh | word_ext;

    fill_up  = fill_a + FILL_W'(7);
    fill_r   = {fill_up[FILL_W-1:3], 3'b000};
    pad_mask = top_mask(fill_r) & ~top_mask(fill_a);

    acc_d  = take_flush ? (acc_a | pad_mask) : acc_a;
    fill_d = take_flush ? fill_r : fill_a;

`ifdef JPEG_BYTE_STUFF_EN
    if (load_stuff)
      stuff_pending_d = 1'b0;
    else if (load_data && (data_byte == 8'hFF))
      stuff_pending_d = 1'b1;
    else
      stuff_pending_d = stuff_pending_q;
`else
    stuff_pending_d = 1'b0;
`endif

    out_valid_d = out_valid_q;
    out_byte_d  = out_byte_q;
    if (load_stuff) begin
      out_valid_d = 1'b1;
      out_byte_d  = 8'h00;
    end else if (load_data) begin
      out_valid_d = 1'b1;
      out_byte_d  = data_byte;
    end else if (out_free) begin
      out_valid_d = 1'b0;
    end

    state_d = state_q;
    unique case (state_q)
      RUN:   if (take_flush) state_d = FLUSH;
      // Nothing can load when fill and stuff are both empty, so a handshake now drains the last byte.
      FLUSH: if ((fill_q == '0) && !stuff_pending_q && out_free) state_d = DONE;
      DONE:  state_d = RUN;
      default: state_d = RUN;
    endcase

    flush_done_d = (state_d == DONE);
    busy_d       = (fill_d != '0) || out_valid_d || stuff_pending_d || (state_d != RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= RUN;
      acc_q           <= '0;
      fill_q          <= '0;
      stuff_pending_q <= 1'b0;
      out_valid_q     <= 1'b0;
      out_byte_q      <= 8'h00;
      flush_done_q    <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      acc_q           <= acc_d;
      fill_q          <= fill_d;
      stuff_pending_q <= stuff_pending_d;
      out_valid_q     <= out_valid_d;
      out_byte_q      <= out_byte_d;
      flush_done_q    <= flush_done_d;
      busy_q          <= busy_d;
    end
  end
endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Directed scoreboard bench for jpeg_bit_packer; expected bytes are queued before stimulus.
`timescale 1ns/1ps
module tb_jpeg_bit_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jpeg_bit_packer_if #(.IN_WIDTH(32)) bus();
  jpeg_bit_packer #(.IN_WIDTH(32), .ACC_WIDTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         tests    = 0;
  int         fails    = 0;
  int         fd_count = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a byte is handshaken at the next rising edge whenever valid and ready are seen here.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.flush_done) fd_count++;
      if (bus.out_valid && bus.out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_byte: got %02h expected none", bus.out_byte);
        end else begin
          mon_exp = exp_q.pop_front();
          if (bus.out_byte !== mon_exp) begin
            fails++;
            $display("FAIL out_byte: got %02h expected %02h", bus.out_byte, mon_exp);
          end else begin
            $display("[TB] byte %02h ok", bus.out_byte);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the word.
  task automatic send(input logic [31:0] b, input int l, input logic fl);
    int n;
    bus.in_valid = 1'b1;
    bus.in_bits  = b;
    bus.in_len   = 6'(l);
    bus.flush    = fl;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) begin
        check("send_timeout", 64'(n), 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    $display("[TB] sent bits=%08h len=%0d flush=%0b", b, l, fl);
  endtask

  // Counts falling edges until flush_done, checking in_ready stays low meanwhile.
  task automatic wait_done(input string name, input int exp_cycles);
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.flush_done) break;
      check({name, "_in_ready_low"}, 64'(bus.in_ready), 64'd0);
      if (cyc > 50) break;
    end
    check({name, "_latency"}, 64'(cyc), 64'(exp_cycles));
    @(negedge clk);
    check({name, "_pulse_width"}, 64'(bus.flush_done), 64'd0);
    check({name, "_ready_again"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    int fd_before;
    bus.in_valid  = 1'b0;
    bus.in_bits   = '0;
    bus.in_len    = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_byte", 64'(bus.out_byte), 64'h00);
    check("rst_flush_done", 64'(bus.flush_done), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // 101 + 10011 -> 0xB3
    exp_q.push_back(8'hB3);
    send(32'h5, 3, 1'b0);
    send(32'h13, 5, 1'b0);
    @(negedge clk);
    check("t1_busy_fill", 64'(bus.busy), 64'd1);
    @(negedge clk);
    check("t1_busy_out", 64'(bus.busy), 64'd1);
    @(negedge clk);
    check("t1_busy_fall", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;

    // 0xFF data byte stuffing
    exp_q.push_back(8'hFF);
`ifdef JPEG_BYTE_STUFF_EN
    exp_q.push_back(8'h00);
`endif
    exp_q.push_back(8'h12);
    send(32'hFF12, 16, 1'b0);
    idle(6);

    // 010 + flush -> 010_11111 = 0x5F
    exp_q.push_back(8'h5F);
    send(32'h2, 3, 1'b1);
    wait_done("t3", 3);

    // Back-pressure: accumulator fills, third word stalls until bytes drain
    bus.out_ready = 1'b0;
    foreach (exp_q[i]) check("t4_queue_clean", 64'(exp_q.size()), 64'd0);
    exp_q.push_back(8'h01); exp_q.push_back(8'h23); exp_q.push_back(8'h45); exp_q.push_back(8'h67);
    exp_q.push_back(8'h89); exp_q.push_back(8'hAB); exp_q.push_back(8'hCD); exp_q.push_back(8'hEF);
    exp_q.push_back(8'hA5); exp_q.push_back(8'hC3); exp_q.push_back(8'h0F); exp_q.push_back(8'h1E);
    send(32'h01234567, 32, 1'b0);
    send(32'h89ABCDEF, 32, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_bits  = 32'hA5C30F1E;
    bus.in_len   = 6'd32;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_third_stalled", 64'(bus.in_ready), 64'd0);
      check("t4_hold_valid", 64'(bus.out_valid), 64'd1);
      check("t4_hold_byte", 64'(bus.out_byte), 64'h01);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    cnt = 0;
    forever begin
      @(negedge clk);
      cnt++;
      if (bus.in_ready || cnt > 50) break;
    end
    check("t4_third_accept_cycles", 64'(cnt), 64'd4);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    idle(12);

    // Zero-length word has no effect; empty flush completes in two cycles
    send(32'hFFFFFFFF, 0, 1'b0);
    idle(4);
    @(negedge clk);
    check("t5_len0_busy", 64'(bus.busy), 64'd0);
    check("t5_len0_no_bytes", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
    send(32'h0, 0, 1'b1);
    wait_done("t5_empty_flush", 2);

    // Reset during FLUSH discards everything
    bus.out_ready = 1'b0;
    send(32'hABC, 12, 1'b1);
    idle(2);
    fd_before = fd_count;
    #2 rst = 1'b1;
    #1;
    check("t6_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("t6_rst_busy", 64'(bus.busy), 64'd0);
    check("t6_rst_in_ready", 64'(bus.in_ready), 64'd1);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    idle(3);
    check("t6_no_flush_done", 64'(fd_count), 64'(fd_before));
    exp_q.push_back(8'h3C);
    send(32'h3C, 8, 1'b0);
    idle(6);

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
